// File: rtl/round_sequencer.sv
// Round sequencer for a show-target / enter-key guessing game.
// Latency: keyValid is asserted one cycle after the accepted key, or after TIMEOUT_CYC cycles of waiting.
// Backpressure: none; keys outside WAIT_KEY and codes above 9 are dropped.
// Ports:
//   clk, reset (async, active-low)     : clock and reset
//   start                              : level request for a new game, honoured in IDLE/DONE only
//   key_pressed, key_code[3:0]         : keypad strobe and value
//   motorValue[3:0]                    : current round target (0..9)
//   inValue[3:0], keyValid             : player answer and its one-cycle qualifier (F = timeout)
//   score_clr                          : one-cycle score clear at game start
//   show_en, busy, done                : target visible / game running / game over
//   round_cnt[3:0]                     : rounds completed in this game
module round_sequencer #(
  parameter int SHOW_CYC    = 100_000_000,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int ROUNDS      = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       key_pressed,
  input  logic [3:0] key_code,
  output logic [3:0] motorValue,
  output logic [3:0] inValue,
  output logic       keyValid,
  output logic       score_clr,
  output logic       show_en,
  output logic       busy,
  output logic       done,
  output logic [3:0] round_cnt
);

  localparam int SHOW_W = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]        ROUNDS_L  = 4'(ROUNDS);

  typedef enum logic [2:0] {IDLE, SHOW, WAIT_KEY, JUDGE, DONE} state_t;

  state_t            state;
  logic [3:0]        lfsr;
  logic [SHOW_W-1:0] show_cnt;
  logic [TO_W-1:0]   to_cnt;

  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

  // Fold LFSR values 10..15 onto 4..9 so the target is always a keypad digit.
  function automatic logic [3:0] to_digit(input logic [3:0] v);
    return (v <= 4'd9) ? v : v - 4'd6;
  endfunction

  logic [3:0] lfsr_adv;
  logic       key_ok;

  assign lfsr_adv = lfsr_next(lfsr);
  assign key_ok   = key_pressed && (key_code <= 4'd9);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lfsr       <= 4'b0001;
      motorValue <= 4'd0;
      inValue    <= 4'd0;
      round_cnt  <= 4'd0;
      keyValid   <= 1'b0;
      score_clr  <= 1'b0;
      show_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      show_cnt   <= '0;
      to_cnt     <= '0;
    end else begin
      // Pulse outputs default low; only the transitions below raise them for one cycle.
      keyValid  <= 1'b0;
      score_clr <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SHOW;
            score_clr  <= 1'b1;
            round_cnt  <= 4'd0;
            lfsr       <= lfsr_adv;
            motorValue <= to_digit(lfsr_adv);
            show_cnt   <= '0;
            to_cnt     <= '0;
            show_en    <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        SHOW: begin
          if (show_cnt == SHOW_LAST) begin
            state    <= WAIT_KEY;
            show_en  <= 1'b0;
            show_cnt <= '0;
            to_cnt   <= '0;
          end else begin
            show_cnt <= show_cnt + 1'b1;
          end
        end
        WAIT_KEY: begin
          // A valid key on the final timeout cycle still wins over the timeout.
          if (key_ok || (to_cnt == TO_LAST)) begin
            state     <= JUDGE;
            inValue   <= key_ok ? key_code : 4'hF;
            keyValid  <= 1'b1;
            round_cnt <= round_cnt + 4'd1;
            to_cnt    <= '0;
            show_cnt  <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        JUDGE: begin
          show_cnt <= '0;
          to_cnt   <= '0;
          if (round_cnt == ROUNDS_L) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= SHOW;
            lfsr       <= lfsr_adv;
            motorValue <= to_digit(lfsr_adv);
            show_en    <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          show_en <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Testbench for round_sequencer: randomized games against a reference model.
// Latency: checks run on falling edges, away from the active clock edge.
// Backpressure: not applicable.
module tb_round_sequencer;

  localparam int SHOW_CYC    = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int ROUNDS      = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       key_pressed = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] motorValue, inValue, round_cnt;
  logic       keyValid, score_clr, show_en, busy, done;

  round_sequencer #(
    .SHOW_CYC(SHOW_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .ROUNDS(ROUNDS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .key_pressed(key_pressed),
    .key_code(key_code),
    .motorValue(motorValue),
    .inValue(inValue),
    .keyValid(keyValid),
    .score_clr(score_clr),
    .show_en(show_en),
    .busy(busy),
    .done(done),
    .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int inv;
    int rc;
    int tgt;
    int wait_cyc;
  } judge_t;

  judge_t jq[$];
  int     tgt_q[$];
  int     clr_pend = 0;
  int     model_lfsr = 1;
  int     model_tgt = 0;
  int     rc_model = 0;
  int     last_inv = 0;
  int     dir_tgt[3] = '{2, 4, 9};

  // Shift left by one, feeding bit3 xor bit2 into bit0.
  function automatic int lfsr_step(input int q);
    return ((q * 2) % 16) + (((q / 8) + (q / 4)) % 2);
  endfunction

  function automatic int as_digit(input int q);
    return (q > 9) ? q - 6 : q;
  endfunction

  task automatic advance_target();
    model_lfsr = lfsr_step(model_lfsr);
    model_tgt  = as_digit(model_lfsr);
    tgt_q.push_back(model_tgt);
  endtask

  // ---------------- monitor ----------------
  bit     prev_show = 1'b0;
  bit     in_wait = 1'b0;
  int     wait_cnt = 0;
  int     show_len = 0;
  int     exp_tgt;
  judge_t jexp;

  always @(negedge clk) begin
    if (!reset) begin
      prev_show = 1'b0;
      in_wait   = 1'b0;
      wait_cnt  = 0;
      show_len  = 0;
    end else begin
      if (show_en && !prev_show) begin
        if (tgt_q.size() > 0) begin
          exp_tgt = tgt_q.pop_front();
          check("motorValue_on_show", motorValue, exp_tgt);
        end else begin
          check("show_entry_unexpected", tgt_q.size(), 1);
        end
        show_len = 0;
      end
      if (show_en) show_len++;
      if (!show_en && prev_show) begin
        check("show_length", show_len, SHOW_CYC);
        in_wait  = 1'b1;
        wait_cnt = 0;
      end
      if (keyValid) begin
        if (jq.size() > 0) begin
          jexp = jq.pop_front();
          check("judge_inValue", inValue, jexp.inv);
          check("judge_round_cnt", round_cnt, jexp.rc);
          check("judge_wait_cycles", wait_cnt, jexp.wait_cyc);
          check("judge_motorValue", motorValue, jexp.tgt);
          check("judge_busy", busy, 1);
          check("judge_show_en", show_en, 0);
        end else begin
          check("keyValid_unexpected", jq.size(), 1);
        end
        in_wait = 1'b0;
      end else if (in_wait) begin
        wait_cnt++;
      end
      if (score_clr) begin
        if (clr_pend > 0) begin
          clr_pend--;
          check("score_clr_round_cnt", round_cnt, 0);
          check("score_clr_show_en", show_en, 1);
        end else begin
          check("score_clr_unexpected", clr_pend, 1);
        end
      end
      prev_show = show_en;
    end
  end

  // ---------------- driver ----------------
  task automatic check_reset_values(input string tag);
    check({tag, "_motorValue"}, motorValue, 0);
    check({tag, "_inValue"}, inValue, 0);
    check({tag, "_round_cnt"}, round_cnt, 0);
    check({tag, "_keyValid"}, keyValid, 0);
    check({tag, "_score_clr"}, score_clr, 0);
    check({tag, "_show_en"}, show_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic wait_show_fall(input bit noise, output bit ok);
    bit seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (show_en) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
      key_pressed = ($urandom_range(0, 3) == 0);
      key_code    = 4'($urandom_range(0, 15));
      if (noise) start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (!ok) check("show_phase_bound", ok, 1);
  endtask

  task automatic reset_abort();
    #2;
    reset       = 1'b0;
    start       = 1'b0;
    key_pressed = 1'b0;
    #1;
    check_reset_values("midgame_reset");
    model_lfsr = 1;
    model_tgt  = 0;
    rc_model   = 0;
    repeat (3) begin
      @(negedge clk);
      check("keyValid_during_reset", keyValid, 0);
    end
    reset = 1'b1;
  endtask

  // Called at WAIT_KEY cycle 0. Key at cycle d, optional invalid code at cycle j.
  task automatic play_round(input bit tmo, input int d, input int kv, input int j, input int inv,
                            input int abort_idx, input bit noise, output bit aborted);
    judge_t e;
    int n;
    bit last;
    aborted = 1'b0;
    last    = 1'b0;
    n = tmo ? TIMEOUT_CYC : d + 1;
    if (abort_idx < 0) begin
      rc_model++;
      last       = (rc_model == ROUNDS);
      e.inv      = tmo ? 15 : kv;
      e.rc       = rc_model;
      e.tgt      = model_tgt;
      e.wait_cyc = tmo ? TIMEOUT_CYC : d + 1;
      last_inv   = e.inv;
      jq.push_back(e);
      if (!last) advance_target();
    end
    for (int i = 0; i < n; i++) begin
      key_pressed = 1'b0;
      key_code    = 4'($urandom_range(0, 15));
      if (noise) start = 1'($urandom_range(0, 1));
      if (i == abort_idx) begin
        reset_abort();
        aborted = 1'b1;
        return;
      end
      if (!tmo && i == d) begin
        key_pressed = 1'b1;
        key_code    = 4'(kv);
      end else if (i == j) begin
        key_pressed = 1'b1;
        key_code    = 4'(inv);
      end
      @(negedge clk);
    end
    key_pressed = 1'b0;
    if (last) start = 1'b0;
  endtask

  task automatic play_game(input bit directed, input bit noise, input int abort_round,
                           input int first_tgt);
    bit ok, aborted, tmo;
    int d, kv, j, inv, ab;
    start = 1'b1;
    clr_pend++;
    rc_model = 0;
    advance_target();
    @(negedge clk);
    if (!noise) start = 1'b0;
    for (int r = 0; r < ROUNDS; r++) begin
      wait_show_fall(noise, ok);
      if (!ok) return;
      if (r == 0 && first_tgt >= 0) check("first_target", motorValue, first_tgt);
      inv = 12;
      j   = -1;
      d   = 0;
      kv  = 0;
      ab  = -1;
      if (directed) begin
        check("directed_target", motorValue, dir_tgt[r]);
        if (r == 0) begin
          tmo = 1'b0; d = 1; kv = 2;
        end else if (r == 1) begin
          tmo = 1'b1;
        end else begin
          tmo = 1'b0; d = TIMEOUT_CYC - 1; kv = 9; j = 2; inv = 12;
        end
      end else begin
        tmo = ($urandom_range(0, 3) == 0);
        d   = $urandom_range(0, TIMEOUT_CYC - 1);
        kv  = $urandom_range(0, 9);
        inv = $urandom_range(10, 15);
        j   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, TIMEOUT_CYC - 1) : -1;
        if (!tmo && j >= d) j = -1;
      end
      if (r == abort_round) begin
        tmo = 1'b1;
        ab  = $urandom_range(1, TIMEOUT_CYC - 1);
      end
      play_round(tmo, d, kv, j, inv, ab, noise, aborted);
      if (aborted) return;
    end
    @(negedge clk);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_round_cnt", round_cnt, ROUNDS);
    check("end_show_en", show_en, 0);
    check("end_inValue", inValue, last_inv);
    check("end_motorValue", motorValue, model_tgt);
    repeat (3) @(negedge clk);
    check("hold_done", done, 1);
    check("hold_motorValue", motorValue, model_tgt);
    check("hold_inValue", inValue, last_inv);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    play_game(1'b1, 1'b0, -1, -1);   // targets 2, 4, 9; key 2, timeout, ignored 12 then key 9 on expiry cycle
    play_game(1'b0, 1'b1, -1, 3);    // restart from DONE, start held high mid-game
    play_game(1'b0, 1'b1, 1, -1);    // reset during round 2 WAIT_KEY
    check("after_abort_busy", busy, 0);
    play_game(1'b0, 1'b0, -1, 2);    // LFSR reseeded by reset
    for (int g = 0; g < 6; g++) play_game(1'b0, 1'($urandom_range(0, 1)), -1, -1);
    repeat (3) @(negedge clk);
    check("judge_queue_drained", jq.size(), 0);
    check("target_queue_drained", tgt_q.size(), 0);
    check("score_clr_drained", clr_pend, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
